// File: rtl/mult_rev_pkg.sv
// Shared definitions for the reversible multiplier pipeline.
//   W_DEFAULT      : default operand width (product is 2*W_DEFAULT bits)
//   unmul_state_t  : state encoding of the sequential uncompute engine
//   unmul_result_t : result bundle produced by the uncompute engine
package mult_rev_pkg;

  localparam int unsigned W_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } unmul_state_t;

  typedef struct packed {
    logic [W_DEFAULT-1:0] a;
    logic [W_DEFAULT-1:0] b;
    logic [W_DEFAULT-1:0] extra;
    logic                 rem_err;
    logic                 ovf;
    logic                 div0;
  } unmul_result_t;

endpackage

// File: rtl/rev_div_step.sv
// One combinational restoring-division step.
//   rem_in  [W:0]   partial remainder before the step
//   bit_in          next dividend bit shifted in at the bottom
//   divisor [W-1:0] divisor (nonzero in normal use)
//   rem_out [W:0]   partial remainder after the step
//   q_bit           quotient bit produced by the step
module rev_div_step #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] dvs;

  // The shifted remainder is W+2 bits wide; its top bit (rem_in[W]) is kept
  // out of the W+1-bit vector and folded into the compare, so nothing is lost.
  // When it is set the true value exceeds any W-bit divisor, and the
  // subtraction done modulo 2^(W+1) still yields the correct remainder.
  always_comb begin
    shifted = {rem_in[W-1:0], bit_in};
    dvs     = {1'b0, divisor};
    q_bit   = rem_in[W] | (shifted >= dvs);
    rem_out = q_bit ? (shifted - dvs) : shifted;
  end

endmodule

// File: rtl/mult8_unmul_seq.sv
// Sequential uncompute engine for the reversible multiplier: given product P
// and pass-through operand A, recovers B = P / A by restoring division, one
// quotient bit per cycle, and flags inexact, out-of-range or divide-by-zero
// uncomputes.
//   clk, rst_n           clock; synchronous active-low reset
//   in_valid/in_ready    request handshake (ready only while idle)
//   in_p [2W-1:0]        product to uncompute
//   in_a [W-1:0]         operand A
//   out_valid/out_ready  result handshake
//   out_a, out_b         A unchanged, recovered B = quotient[W-1:0]
//   out_extra            P[2W-1:W] of the latched product
//   out_rem_err          remainder nonzero
//   out_ovf              quotient[2W-1:W] nonzero
//   out_div0             A was zero
module mult8_unmul_seq
  import mult_rev_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_p,
  input  logic [W-1:0]   in_a,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_a,
  output logic [W-1:0]   out_b,
  output logic [W-1:0]   out_extra,
  output logic           out_rem_err,
  output logic           out_ovf,
  output logic           out_div0
);

  localparam int unsigned CW = $clog2(2 * W);

  unmul_state_t   state_q, state_d;
  logic [2*W-1:0] p_q, p_d;
  logic [W-1:0]   a_q, a_d;
  logic [W:0]     rem_q, rem_d;
  logic [2*W-1:0] quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_a_q, out_a_d;
  logic [W-1:0]   out_b_q, out_b_d;
  logic [W-1:0]   out_extra_q, out_extra_d;
  logic           rem_err_q, rem_err_d;
  logic           ovf_q, ovf_d;
  logic           div0_q, div0_d;

  logic [W:0]     step_rem;
  logic           step_q;

  rev_div_step #(.W(W)) u_step (
    .rem_in  (rem_q),
    .bit_in  (p_q[cnt_q]),
    .divisor (a_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    a_d         = a_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_extra_d = out_extra_q;
    rem_err_d   = rem_err_q;
    ovf_d       = ovf_q;
    div0_d      = div0_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          p_d   = in_p;
          a_d   = in_a;
          rem_d = '0;
          quo_d = '0;
          if (in_a == '0) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            out_a_d     = in_a;
            out_b_d     = '0;
            out_extra_d = in_p[2*W-1:W];
            rem_err_d   = 1'b0;
            ovf_d       = 1'b0;
            div0_d      = 1'b1;
          end else begin
            state_d = S_DIV;
            cnt_d   = CW'(2 * W - 1);
          end
        end
      end

      S_DIV: begin
        rem_d        = step_rem;
        quo_d[cnt_q] = step_q;
        cnt_d        = cnt_q - 1'b1;
        // The final step's result is captured straight into the output
        // registers so DONE presents it without an extra cycle.
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_a_d     = a_q;
          out_b_d     = quo_d[W-1:0];
          out_extra_d = p_q[2*W-1:W];
          rem_err_d   = |rem_d;
          ovf_d       = |quo_d[2*W-1:W];
          div0_d      = 1'b0;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      a_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_extra_q <= '0;
      rem_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      a_q         <= a_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_extra_q <= out_extra_d;
      rem_err_q   <= rem_err_d;
      ovf_q       <= ovf_d;
      div0_q      <= div0_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_extra   = out_extra_q;
  assign out_rem_err = rem_err_q;
  assign out_ovf     = ovf_q;
  assign out_div0    = div0_q;

endmodule

// File: tb/tb_mult8_unmul_seq.sv
module tb_mult8_unmul_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_p;
  logic [7:0]  in_a;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic [7:0]  out_extra;
  logic        out_rem_err;
  logic        out_ovf;
  logic        out_div0;

  mult8_unmul_seq #(.W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_p        (in_p),
    .in_a        (in_a),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_extra   (out_extra),
    .out_rem_err (out_rem_err),
    .out_ovf     (out_ovf),
    .out_div0    (out_div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] extra;
    logic       rem_err;
    logic       ovf;
    logic       div0;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_acc = 0;
  bit   have_last = 1'b0;
  bit   btb = 1'b0;
  bit   accepted = 1'b0;
  bit   vprev = 1'b0;

  // Reference: plain integer division; latency in cycles from the accept cycle.
  function automatic exp_t model(input logic [15:0] p, input logic [7:0] a);
    exp_t        e;
    int unsigned pv, av, q, r;
    pv = p;
    av = a;
    e.a     = a;
    e.extra = p[15:8];
    if (av == 0) begin
      e.b = '0; e.rem_err = 1'b0; e.ovf = 1'b0; e.div0 = 1'b1; e.lat = 1;
    end else begin
      q = pv / av;
      r = pv % av;
      e.b = q[7:0]; e.rem_err = (r != 0); e.ovf = (q > 255); e.div0 = 1'b0; e.lat = 17;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at negedge (accepts, outputs), advance past posedge.
  task automatic tick();
    @(negedge clk);
    if (in_valid && in_ready) begin
      exp_t e;
      e = model(in_p, in_a);
      sb.push_back(e);
      acc_q.push_back(cyc);
      if (btb && have_last) chk("accept_spacing", cyc - last_acc, 18);
      last_acc  = cyc;
      have_last = 1'b1;
      accepted  = 1'b1;
    end
    if (sb.size() == 0) begin
      chk("no_spurious_valid", out_valid, 0);
    end else if (out_valid) begin
      if (!vprev && acc_q.size() > 0) chk("latency", cyc - acc_q.pop_front(), sb[0].lat);
      chk("out_a",       out_a,       sb[0].a);
      chk("out_b",       out_b,       sb[0].b);
      chk("out_extra",   out_extra,   sb[0].extra);
      chk("out_rem_err", out_rem_err, sb[0].rem_err);
      chk("out_ovf",     out_ovf,     sb[0].ovf);
      chk("out_div0",    out_div0,    sb[0].div0);
      chk("in_ready_done", in_ready, 0);
      if (out_ready) void'(sb.pop_front());
    end
    vprev = out_valid;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [15:0] p, input logic [7:0] a);
    int n;
    in_p     = p;
    in_a     = a;
    in_valid = 1'b1;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 100) begin
      tick();
      n++;
    end
    if (!accepted) chk("accept_timeout", accepted, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    logic [7:0]  b;
    logic [15:0] p;
    int          n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_p      = '0;
    in_a      = '0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_in_ready",  in_ready,    1);
    chk("rst_out_valid", out_valid,   0);
    chk("rst_out_a",     out_a,       0);
    chk("rst_out_b",     out_b,       0);
    chk("rst_out_extra", out_extra,   0);
    chk("rst_flags",     {out_rem_err, out_ovf, out_div0}, 0);
    rst_n = 1'b1;
    tick();

    // 1: exact quotient, 17-cycle latency
    send(16'h0048, 8'h12);
    drain();

    // 2: hold out_ready low for 5 cycles while the result is valid
    out_ready = 1'b0;
    send(16'h0088, 8'h08);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("hold_valid_seen", out_valid, 1);
    repeat (5) tick();
    out_ready = 1'b1;
    drain();

    // 3: inexact and overflowing quotient
    send(16'h8C40, 8'h12);
    drain();

    // 4: divide by zero
    send(16'h1234, 8'h00);
    drain();

    // 5: reset during the sixth DIV cycle aborts the operation
    send(16'h0088, 8'h08);
    repeat (5) tick();
    sb.delete();
    acc_q.delete();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vprev = 1'b0;
    chk("abort_in_ready",  in_ready,  1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_b",     out_b,     0);
    repeat (25) tick();

    // 6: back-to-back sweep over every nonzero A
    btb       = 1'b1;
    have_last = 1'b0;
    for (int unsigned a = 1; a < 256; a++) begin
      b = 8'($urandom_range(0, 255));
      p = 16'(a) * 16'(b);
      send(p, 8'(a));
    end
    drain();
    btb = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
